wt_dcache_rrip: RTL

// Parametrised RRIP replacement unit for the write-through L1 dcache.

---
 rtl/wt_dcache_rrip_if.sv | 28 ++
 rtl/wt_dcache_rrip.sv | 124 ++++++++++++
 2 files changed

// File: rtl/wt_dcache_rrip_if.sv
// wt_dcache_rrip_if: hit/miss/flush request bundle between the dcache and its RRIP replacement unit.
interface wt_dcache_rrip_if #(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 256
);
    localparam int IW = $clog2(NUM_SETS);
    localparam int WW = $clog2(NUM_WAYS);
    logic                flush_i;
    logic                busy_o;
    logic                hit_i;
    logic [IW-1:0]       hit_idx_i;
    logic [WW-1:0]       hit_way_i;
    logic                miss_i;
    logic [IW-1:0]       miss_idx_i;
    logic [NUM_WAYS-1:0] valid_i;
    logic [1:0]          pred_i;
    logic [WW-1:0]       victim_o;
    logic                conflict_o;
    logic                brrip_o;
    modport master (
        output flush_i, hit_i, hit_idx_i, hit_way_i, miss_i, miss_idx_i, valid_i, pred_i,
        input  busy_o, victim_o, conflict_o, brrip_o
    );
    modport slave (
        input  flush_i, hit_i, hit_idx_i, hit_way_i, miss_i, miss_idx_i, valid_i, pred_i,
        output busy_o, victim_o, conflict_o, brrip_o
    );
endinterface

// File: rtl/wt_dcache_rrip.sv
// wt_dcache_rrip: SRRIP victim selection, RRPV update and flush sweep for the write-through dcache.
// Defining WT_DCACHE_DRRIP_EN adds set dueling between SRRIP and BRRIP insertion.
module wt_dcache_rrip #(
    parameter int NUM_WAYS     = 4,
    parameter int NUM_SETS     = 256,
    parameter int RRPV_W       = 2
`ifdef WT_DCACHE_DRRIP_EN
    ,
    parameter int BRRIP_PERIOD = 32,
    parameter int PSEL_W       = 10
`endif
) (
    input logic             clk_i,
    input logic             rst_ni,
    wt_dcache_rrip_if.slave bus
);
    localparam int IW = $clog2(NUM_SETS);
    localparam int WW = $clog2(NUM_WAYS);
    localparam logic [RRPV_W-1:0] RMAX = '1;
    localparam logic [RRPV_W-1:0] RLONG = RMAX - RRPV_W'(1);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SWEEP = 1'b1;

    logic [NUM_WAYS-1:0][RRPV_W-1:0] rows [NUM_SETS];
    logic [NUM_WAYS-1:0][RRPV_W-1:0] cur, nxt;
    logic [0:0]        state_q;
    logic [IW-1:0]     cnt_q;
    logic [RRPV_W-1:0] max_r, age, ins, def_ins;
    logic [WW-1:0]     inv_way, max_way, vic;
    logic              busy, inv_any, do_miss, do_hit, same, conflict;

    assign busy    = state_q == SWEEP;
    assign do_miss = bus.miss_i & ~busy;
    assign do_hit  = bus.hit_i & ~busy;
    assign cur     = rows[bus.miss_idx_i];
    assign inv_any = ~&bus.valid_i;
    assign age     = RMAX - max_r;
    assign vic     = inv_any ? inv_way : max_way;
    assign same    = do_miss & do_hit & (bus.hit_idx_i == bus.miss_idx_i);
    assign conflict = same & (bus.hit_way_i == vic);
    assign ins = bus.pred_i == 2'b00 ? def_ins :
                 bus.pred_i == 2'b01 ? RMAX :
                 bus.pred_i == 2'b10 ? RLONG : '0;

    // The way holding the largest RRPV is the one that reaches RMAX after aging.
    always_comb begin
        max_r   = '0;
        inv_way = '0;
        max_way = '0;
        nxt     = '0;
        for (int w = 0; w < NUM_WAYS; w++)
            max_r = cur[w] > max_r ? cur[w] : max_r;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            inv_way = bus.valid_i[w] ? inv_way : WW'(w);
            max_way = cur[w] == max_r ? WW'(w) : max_way;
        end
        for (int w = 0; w < NUM_WAYS; w++)
            nxt[w] = (same && !conflict && bus.hit_way_i == WW'(w)) ? '0 :
                     vic == WW'(w) ? ins :
                     inv_any ? cur[w] : cur[w] + age;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (bus.flush_i) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
        end else if (busy) begin
            state_q <= cnt_q == IW'(NUM_SETS - 1) ? IDLE : SWEEP;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
        logic [NUM_WAYS-1:0][RRPV_W-1:0] row_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)
                row_q <= '1;
            else if (busy && cnt_q == IW'(s))
                row_q <= '1;
            else if (do_miss && bus.miss_idx_i == IW'(s))
                row_q <= nxt;
            else if (do_hit && bus.hit_idx_i == IW'(s))
                row_q[bus.hit_way_i] <= '0;
        end
        assign rows[s] = row_q;
    end

`ifdef WT_DCACHE_DRRIP_EN
    localparam int BW = $clog2(BRRIP_PERIOD);
    logic [PSEL_W-1:0] psel_q;
    logic [BW-1:0]     brr_q;
    logic              lead_s, lead_b, use_brrip;

    assign lead_s    = bus.miss_idx_i[4:0] == 5'd0;
    assign lead_b    = bus.miss_idx_i[4:0] == 5'd31;
    assign use_brrip = lead_b | (~lead_s & psel_q[PSEL_W-1]);
    assign def_ins   = use_brrip && brr_q != BW'(BRRIP_PERIOD - 1) ? RMAX : RLONG;
    assign bus.brrip_o = psel_q[PSEL_W-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            psel_q <= {1'b1, {(PSEL_W-1){1'b0}}};
            brr_q  <= '0;
        end else begin
            if (do_miss && lead_s && !(&psel_q))
                psel_q <= psel_q + 1'b1;
            else if (do_miss && lead_b && |psel_q)
                psel_q <= psel_q - 1'b1;
            if (do_miss && use_brrip && bus.pred_i == 2'b00)
                brr_q <= brr_q == BW'(BRRIP_PERIOD - 1) ? '0 : brr_q + 1'b1;
        end
    end
`else
    assign def_ins     = RLONG;
    assign bus.brrip_o = 1'b0;
`endif

    assign bus.busy_o     = busy;
    assign bus.victim_o   = do_miss ? vic : '0;
    assign bus.conflict_o = conflict;
endmodule
